// File: rtl/fetch_responder_pkg.sv
// Shared types and constants for the fetch-port memory responder.
// Holds the FSM encoding, default parameter values and the word-align helper.
package fetch_responder_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        REQUEST = 1'b1
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // All-zero decodes as an illegal instruction in the pipe.
    localparam logic [31:0] ERROR_INSTRUCTION_DEFAULT = 32'h0000_0000;

    // Byte offset bits are dropped; misalignment is flagged upstream.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_responder_timer.sv
// Bus wait-state counter with terminal-count flag.
// Ports: clk, rst (async active-low), i_clear, i_enable, o_terminal.
module fetch_responder_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Asserted during the final permitted cycle of a bus read.
    assign o_terminal = (r_count == LP_LAST);

endmodule

// File: rtl/fetch_responder.sv
// Fetch-port responder: one-word instruction buffer, single-outstanding
// bus reads, flush and timeout. Ports: clk, rst (async active-low),
// fetchAddress/fetchEnable in, fetchBusy/fetchData/fetchError out, flush in,
// memAddress/memRequest out, memAck/memReadData in.
module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [31:0] ERROR_INSTRUCTION = ERROR_INSTRUCTION_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetchAddress,
    input  logic        fetchEnable,
    output logic        fetchBusy,
    output logic [31:0] fetchData,
    output logic        fetchError,
    input  logic        flush,
    output logic [31:0] memAddress,
    output logic        memRequest,
    input  logic        memAck,
    input  logic [31:0] memReadData
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_bufValid;
    logic [31:0] r_bufAddress;
    logic [31:0] r_bufData;
    logic        r_bufError;
    logic        r_discard;
    logic [31:0] r_memAddress;

    logic [31:0] w_wa;
    logic        w_hit;
    logic        w_issue;
    logic        w_fill;
    logic        w_tmoFill;
    logic        w_done;
    logic        w_setDiscard;
    logic        w_tmrEn;
    logic        w_terminal;

    assign w_wa  = word_align(fetchAddress);
    assign w_hit = r_bufValid && (r_bufAddress == w_wa) && !flush;

    assign fetchBusy  = fetchEnable && !w_hit;
    assign fetchData  = w_hit ? r_bufData : 32'h0;
    assign fetchError = w_hit && r_bufError;

    assign memRequest = (r_state == REQUEST);
    assign memAddress = r_memAddress;

    // Counter runs only while the read is still waiting.
    assign w_tmrEn = (r_state == REQUEST) && !memAck;

    fetch_responder_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_issue),
        .i_enable   (w_tmrEn),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_fill       = 1'b0;
        w_tmoFill    = 1'b0;
        w_done       = 1'b0;
        w_setDiscard = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (fetchEnable && !w_hit && !flush) begin
                    w_issue     = 1'b1;
                    w_state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                if (memAck) begin
                    w_done      = 1'b1;
                    w_fill      = !r_discard && !flush;
                    w_state_nxt = IDLE;
                end else if (w_terminal) begin
                    w_done      = 1'b1;
                    w_tmoFill   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (flush) begin
                    // Result of this read belongs to a stale stream.
                    w_setDiscard = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_memAddress <= 32'h0;
        end else if (w_issue) begin
            r_memAddress <= w_wa;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bufValid   <= 1'b0;
            r_bufAddress <= 32'h0;
            r_bufData    <= 32'h0;
            r_bufError   <= 1'b0;
        end else begin
            if (w_fill) begin
                r_bufValid   <= 1'b1;
                r_bufAddress <= r_memAddress;
                r_bufData    <= memReadData;
                r_bufError   <= 1'b0;
            end else if (w_tmoFill) begin
                r_bufValid   <= !r_discard && !flush;
                r_bufAddress <= r_memAddress;
                r_bufData    <= ERROR_INSTRUCTION;
                r_bufError   <= 1'b1;
            end
            // Flush overrides any same-cycle load.
            if (flush) begin
                r_bufValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_discard <= 1'b0;
        end else if (w_done) begin
            r_discard <= 1'b0;
        end else if (w_setDiscard) begin
            r_discard <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder with a transaction-level reference.
// A bench-side memory answers bus reads after a programmable wait count.
module tb_fetch_responder;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetchAddress = 32'h0;
    logic        fetchEnable = 1'b0;
    logic        fetchBusy;
    logic [31:0] fetchData;
    logic        fetchError;
    logic        flush = 1'b0;
    logic [31:0] memAddress;
    logic        memRequest;
    logic        memAck = 1'b0;
    logic [31:0] memReadData = 32'h0;

    int errors = 0;
    int checks = 0;
    int wait_states = 0;
    int wcnt = 0;
    int nreq = 0;
    logic prevReq = 1'b0;

    fetch_responder #(
        .TIMEOUT_CYCLES    (TMO),
        .ERROR_INSTRUCTION (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetchAddress (fetchAddress),
        .fetchEnable  (fetchEnable),
        .fetchBusy    (fetchBusy),
        .fetchData    (fetchData),
        .fetchError   (fetchError),
        .flush        (flush),
        .memAddress   (memAddress),
        .memRequest   (memRequest),
        .memAck       (memAck),
        .memReadData  (memReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Bench memory: acks after wait_states idle request cycles.
    always @(posedge clk) begin
        #1;
        if (memRequest) begin
            if (wcnt == wait_states) begin
                memAck      = 1'b1;
                memReadData = memword(memAddress);
            end else begin
                memAck = 1'b0;
            end
            wcnt++;
        end else begin
            memAck      = 1'b0;
            memReadData = 32'hDEAD_BEEF;
            wcnt        = 0;
        end
    end

    // Reference: buffer contents plus one pending read.
    logic        mv = 1'b0;
    logic [31:0] ma = 32'h0;
    logic [31:0] md = 32'h0;
    logic        me = 1'b0;
    logic        mpend = 1'b0;
    logic        mdisc = 1'b0;
    logic [31:0] mpa = 32'h0;
    int          mage = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mv <= 1'b0; ma <= 32'h0; md <= 32'h0; me <= 1'b0;
            mpend <= 1'b0; mdisc <= 1'b0; mpa <= 32'h0; mage <= 0;
        end else begin
            logic [31:0] w;
            logic h;
            w = {fetchAddress[31:2], 2'b00};
            h = mv && (ma == w) && !flush;
            if (!mpend) begin
                if (fetchEnable && !h && !flush) begin
                    mpend <= 1'b1; mpa <= w; mage <= 1; mdisc <= 1'b0;
                end
            end else if (memAck) begin
                mpend <= 1'b0;
                mdisc <= 1'b0;
                if (!mdisc && !flush) begin
                    mv <= 1'b1; ma <= mpa; md <= memword(mpa); me <= 1'b0;
                end
            end else if (mage == TMO) begin
                mpend <= 1'b0; mdisc <= 1'b0;
                ma <= mpa; md <= 32'h0; me <= 1'b1;
                mv <= !mdisc && !flush;
            end else begin
                mage <= mage + 1;
                if (flush) mdisc <= 1'b1;
            end
            if (flush) mv <= 1'b0;
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        logic eh;
        eh = mv && (ma == {fetchAddress[31:2], 2'b00}) && !flush;
        check("fetchBusy", 32'(fetchBusy), 32'(fetchEnable && !eh));
        check("fetchData", fetchData, eh ? md : 32'h0);
        check("fetchError", 32'(fetchError), 32'(eh && me));
        check("memRequest", 32'(memRequest), 32'(mpend));
        check("memAddress", memAddress, mpa);
        if (memRequest && !prevReq) nreq++;
        prevReq = memRequest;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!fetchBusy) break;
        end
        check("ready_bound", 32'(fetchBusy), 32'h0);
    endtask

    initial begin
        int n0;
        int b;
        int cnt;

        // Reset state
        @(negedge clk);
        check("rst_memRequest", 32'(memRequest), 32'h0);
        check("rst_memAddress", memAddress, 32'h0);
        check("rst_fetchData", fetchData, 32'h0);
        step();
        rst = 1'b1;

        // First miss, zero-wait ack
        wait_states = 0;
        step();
        fetchEnable  = 1'b1;
        fetchAddress = 32'h100;
        @(negedge clk);
        check("t1_busy_N", 32'(fetchBusy), 32'h1);
        step();
        @(negedge clk);
        check("t1_req", 32'(memRequest), 32'h1);
        check("t1_addr", memAddress, 32'h100);
        step();
        @(negedge clk);
        check("t1_busy_N2", 32'(fetchBusy), 32'h0);
        check("t1_data", fetchData, 32'h0050_0093);
        step();
        fetchAddress = 32'h102;
        @(negedge clk);
        check("t1_hit102", fetchData, 32'h0050_0093);
        step();
        step();
        @(negedge clk);
        check("t1_nreq", 32'(nreq), 32'd1);

        // Three wait states
        wait_states = 3;
        step();
        fetchAddress = 32'h104;
        b = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fetchBusy) b++;
            @(posedge clk);
        end
        #1;
        @(negedge clk);
        check("t2_busy_cycles", 32'(b), 32'd5);
        check("t2_data", fetchData, memword(32'h104));
        check("t2_nreq", 32'(nreq), 32'd2);
        wait_states = 0;
        step();
        fetchAddress = 32'h100;
        @(negedge clk);
        check("t2_100_miss", 32'(fetchBusy), 32'h1);
        wait_ready(20);

        // Address change during REQUEST
        wait_states = 2;
        n0 = nreq;
        step();
        fetchAddress = 32'h200;
        step();
        fetchAddress = 32'h300;
        wait_ready(30);
        check("t3_data", fetchData, memword(32'h300));
        check("t3_nreq", 32'(nreq - n0), 32'd2);

        // Flush mid-REQUEST
        n0 = nreq;
        step();
        fetchAddress = 32'h400;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        @(negedge clk);
        check("t4_busy", 32'(fetchBusy), 32'h1);
        check("t4_req_gap", 32'(memRequest), 32'h0);
        wait_ready(30);
        check("t4_data", fetchData, memword(32'h400));
        check("t4_nreq", 32'(nreq - n0), 32'd2);

        // Timeout
        wait_states = 1000;
        step();
        fetchAddress = 32'h500;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (memRequest) cnt++;
            else if (cnt > 0) break;
            @(posedge clk);
        end
        check("t5_req_cycles", 32'(cnt), 32'd255);
        check("t5_busy", 32'(fetchBusy), 32'h0);
        check("t5_data", fetchData, 32'h0);
        check("t5_err", 32'(fetchError), 32'h1);
        wait_states = 0;
        step();
        fetchAddress = 32'h504;
        @(negedge clk);
        check("t5_err_clr", 32'(fetchError), 32'h0);
        check("t5_busy504", 32'(fetchBusy), 32'h1);
        wait_ready(20);
        check("t5_data504", fetchData, memword(32'h504));

        // Flush with enable in IDLE delays the request
        step();
        fetchAddress = 32'h700;
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t7_noreq", 32'(memRequest), 32'h0);
        step();
        @(negedge clk);
        check("t7_req", 32'(memRequest), 32'h1);
        wait_ready(20);

        // Asynchronous reset mid-REQUEST
        wait_states = 5;
        step();
        fetchAddress = 32'h600;
        step();
        #1;
        rst = 1'b0;
        #1;
        check("t6_req_drop", 32'(memRequest), 32'h0);
        check("t6_addr_rst", memAddress, 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t6_miss", 32'(fetchBusy), 32'h1);
        wait_ready(30);
        check("t6_data", fetchData, memword(32'h600));
        check("t6_err", 32'(fetchError), 32'h0);

        step();
        fetchEnable = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
